// File: rtl/lane_dir_pkg.sv
// Shared types for the single-lane east/west direction controller:
// FSM state encoding and travel direction, plus small direction helpers.
package lane_dir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GO_E,
        GO_W,
        DRAIN
    } state_e;

    typedef enum logic {
        EAST,
        WEST
    } dir_e;

    function automatic state_e go_state(input dir_e d);
        if (d == EAST) begin
            return GO_E;
        end
        return GO_W;
    endfunction

    function automatic dir_e opposite(input dir_e d);
        if (d == EAST) begin
            return WEST;
        end
        return EAST;
    endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter. Simultaneous inc and dec cancel; an inc at full
// scale or a dec at zero is dropped and raises a registered one-cycle ovf.
module sat_updown_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (inc && !dec) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec && !inc) begin
            if (cnt_q == '0) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/lane_dir_ctrl.sv
// Shared-lane direction controller: per-direction arrival queues, lane
// occupancy, bounded bursts, and a drain-plus-clearance gap before reversal.
module lane_dir_ctrl
    import lane_dir_pkg::*;
#(
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned CLEAR_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_arrive,
    input  logic             w_arrive,
    input  logic             exit,
    output logic             e_go,
    output logic             w_go,
    output logic             e_enter,
    output logic             w_enter,
    output logic             idle,
    output logic [CNT_W-1:0] occ,
    output logic [CNT_W-1:0] e_wait,
    output logic [CNT_W-1:0] w_wait,
    output logic             ovf
);

    localparam int unsigned     TMR_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    state_e           state_q;
    dir_e             next_dir_q;
    dir_e             last_dir_q;
    dir_e             idle_pick;
    logic [CNT_W-1:0] burst_q;
    logic [CNT_W-1:0] burst_nxt;
    logic [TMR_W-1:0] timer_q;

    logic e_has, w_has, occ_zero, grant;
    logic e_ovf, w_ovf, occ_ovf;

    sat_updown_cnt #(
        .W (CNT_W)
    ) u_e_wait (
        .clk   (clk),
        .reset (reset),
        .inc   (e_arrive),
        .dec   (e_enter),
        .cnt   (e_wait),
        .ovf   (e_ovf)
    );

    sat_updown_cnt #(
        .W (CNT_W)
    ) u_w_wait (
        .clk   (clk),
        .reset (reset),
        .inc   (w_arrive),
        .dec   (w_enter),
        .cnt   (w_wait),
        .ovf   (w_ovf)
    );

    sat_updown_cnt #(
        .W (CNT_W)
    ) u_occ (
        .clk   (clk),
        .reset (reset),
        .inc   (grant),
        .dec   (exit),
        .cnt   (occ),
        .ovf   (occ_ovf)
    );

    assign e_go     = (state_q == GO_E);
    assign w_go     = (state_q == GO_W);
    assign idle     = (state_q == IDLE);
    assign e_has    = (e_wait != '0);
    assign w_has    = (w_wait != '0);
    assign occ_zero = (occ == '0);
    assign e_enter  = e_go && e_has;
    assign w_enter  = w_go && w_has;
    assign grant    = e_enter || w_enter;
    assign ovf      = e_ovf || w_ovf || occ_ovf;

    // Burst limit is judged on the count including this cycle's grant, so
    // exactly MAX_BURST vehicles pass before the lane is handed over.
    assign burst_nxt = (grant && burst_q != BURST_MAX) ? burst_q + 1'b1 : burst_q;

    always_comb begin
        idle_pick = WEST;
        if (e_has && w_has) begin
            idle_pick = opposite(last_dir_q);
        end else if (e_has) begin
            idle_pick = EAST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            next_dir_q <= EAST;
            last_dir_q <= WEST;
            burst_q    <= '0;
            timer_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (e_has || w_has) begin
                        state_q    <= go_state(idle_pick);
                        last_dir_q <= idle_pick;
                        burst_q    <= '0;
                    end
                end
                GO_E: begin
                    burst_q <= burst_nxt;
                    if (w_has && (!e_has || burst_nxt == BURST_MAX)) begin
                        state_q    <= DRAIN;
                        next_dir_q <= WEST;
                        timer_q    <= '0;
                    end else if (!e_has && !w_has && occ_zero) begin
                        state_q <= IDLE;
                    end
                end
                GO_W: begin
                    burst_q <= burst_nxt;
                    if (e_has && (!w_has || burst_nxt == BURST_MAX)) begin
                        state_q    <= DRAIN;
                        next_dir_q <= EAST;
                        timer_q    <= '0;
                    end else if (!e_has && !w_has && occ_zero) begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    // Clearance only counts once the lane is physically empty.
                    if (!occ_zero) begin
                        timer_q <= '0;
                    end else if (timer_q == TMR_LAST) begin
                        state_q    <= go_state(next_dir_q);
                        last_dir_q <= next_dir_q;
                        burst_q    <= '0;
                        timer_q    <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_go_mutex: assert property (@(posedge clk) disable iff (reset) !(e_go && w_go));

endmodule

// File: tb/tb_lane_dir_ctrl.sv
// Self-checking bench for lane_dir_ctrl: three configurations, cycle-exact
// checks plus a scoreboard of expected admission directions (0=east, 1=west).
module tb_lane_dir_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;

    // a: defaults (4, 8, 3); b: MAX_BURST=2; c: CNT_W=2
    logic       e_arr_a = 0, w_arr_a = 0, exit_a = 0;
    logic       e_go_a, w_go_a, e_ent_a, w_ent_a, idle_a, ovf_a;
    logic [3:0] occ_a, e_wait_a, w_wait_a;

    logic       e_arr_b = 0, w_arr_b = 0, exit_b = 0;
    logic       e_go_b, w_go_b, e_ent_b, w_ent_b, idle_b, ovf_b;
    logic [3:0] occ_b, e_wait_b, w_wait_b;

    logic       e_arr_c = 0, w_arr_c = 0, exit_c = 0;
    logic       e_go_c, w_go_c, e_ent_c, w_ent_c, idle_c, ovf_c;
    logic [1:0] occ_c, e_wait_c, w_wait_c;

    lane_dir_ctrl #(.CNT_W(4), .MAX_BURST(8), .CLEAR_CYCLES(3)) dut_a (
        .clk(clk), .reset(reset), .e_arrive(e_arr_a), .w_arrive(w_arr_a), .exit(exit_a),
        .e_go(e_go_a), .w_go(w_go_a), .e_enter(e_ent_a), .w_enter(w_ent_a), .idle(idle_a),
        .occ(occ_a), .e_wait(e_wait_a), .w_wait(w_wait_a), .ovf(ovf_a)
    );

    lane_dir_ctrl #(.CNT_W(4), .MAX_BURST(2), .CLEAR_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .e_arrive(e_arr_b), .w_arrive(w_arr_b), .exit(exit_b),
        .e_go(e_go_b), .w_go(w_go_b), .e_enter(e_ent_b), .w_enter(w_ent_b), .idle(idle_b),
        .occ(occ_b), .e_wait(e_wait_b), .w_wait(w_wait_b), .ovf(ovf_b)
    );

    lane_dir_ctrl #(.CNT_W(2), .MAX_BURST(3), .CLEAR_CYCLES(3)) dut_c (
        .clk(clk), .reset(reset), .e_arrive(e_arr_c), .w_arrive(w_arr_c), .exit(exit_c),
        .e_go(e_go_c), .w_go(w_go_c), .e_enter(e_ent_c), .w_enter(w_ent_c), .idle(idle_c),
        .occ(occ_c), .e_wait(e_wait_c), .w_wait(w_wait_c), .ovf(ovf_c)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int q_a[$];
    int q_b[$];
    int q_c[$];
    bit done;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        e_arr_a = 0; w_arr_a = 0; exit_a = 0;
        e_arr_b = 0; w_arr_b = 0; exit_b = 0;
        e_arr_c = 0; w_arr_c = 0; exit_c = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard: every admission pops the expected direction.
    always @(negedge clk) begin
        check_eq("a_go_mutex", int'(e_go_a && w_go_a), 0);
        check_eq("b_go_mutex", int'(e_go_b && w_go_b), 0);
        check_eq("c_go_mutex", int'(e_go_c && w_go_c), 0);
        if (e_ent_a || w_ent_a) begin
            check_eq("a_sb_nonempty", int'(q_a.size() != 0), 1);
            if (q_a.size() != 0) check_eq("a_enter_dir", int'(w_ent_a), q_a.pop_front());
        end
        if (e_ent_b || w_ent_b) begin
            check_eq("b_sb_nonempty", int'(q_b.size() != 0), 1);
            if (q_b.size() != 0) check_eq("b_enter_dir", int'(w_ent_b), q_b.pop_front());
        end
        if (e_ent_c || w_ent_c) begin
            check_eq("c_sb_nonempty", int'(q_c.size() != 0), 1);
            if (q_c.size() != 0) check_eq("c_enter_dir", int'(w_ent_c), q_c.pop_front());
        end
    end

    initial begin
        #1 reset = 1'b1;
        #2;
        check_eq("rst_idle", int'(idle_a), 1);
        check_eq("rst_e_go", int'(e_go_a), 0);
        check_eq("rst_w_go", int'(w_go_a), 0);
        check_eq("rst_enter", int'(e_ent_a || w_ent_a), 0);
        check_eq("rst_occ", int'(occ_a), 0);
        check_eq("rst_ovf", int'(ovf_a), 0);
        do_reset();

        // Single east vehicle: arrive t0, enter t2, exit, back to IDLE.
        q_a.push_back(0);
        e_arr_a = 1; cyc(1); e_arr_a = 0;
        check_eq("t1_e_wait", int'(e_wait_a), 1);
        check_eq("t1_idle", int'(idle_a), 1);
        cyc(1);
        check_eq("t1_e_go", int'(e_go_a), 1);
        check_eq("t1_e_enter", int'(e_ent_a), 1);
        cyc(1);
        check_eq("t1_occ", int'(occ_a), 1);
        check_eq("t1_e_wait0", int'(e_wait_a), 0);
        exit_a = 1; cyc(1); exit_a = 0;
        check_eq("t1_occ0", int'(occ_a), 0);
        cyc(1);
        check_eq("t1_back_idle", int'(idle_a), 1);

        // 3 east + 3 west together: east first, drain, clearance, west.
        do_reset();
        for (int i = 0; i < 3; i++) q_a.push_back(0);
        for (int i = 0; i < 3; i++) q_a.push_back(1);
        e_arr_a = 1; w_arr_a = 1; cyc(3); e_arr_a = 0; w_arr_a = 0;
        cyc(3);
        check_eq("t2_drain_e_go", int'(e_go_a), 0);
        check_eq("t2_drain_idle", int'(idle_a), 0);
        check_eq("t2_drain_occ", int'(occ_a), 3);
        check_eq("t2_drain_w_wait", int'(w_wait_a), 3);
        exit_a = 1; cyc(3); exit_a = 0;
        check_eq("t2_occ0", int'(occ_a), 0);
        cyc(2);
        check_eq("t2_w_go_early", int'(w_go_a), 0);
        cyc(1);
        check_eq("t2_w_go", int'(w_go_a), 1);
        check_eq("t2_w_enter", int'(w_ent_a), 1);
        cyc(3);
        check_eq("t2_occ3", int'(occ_a), 3);
        check_eq("t2_w_wait0", int'(w_wait_a), 0);
        exit_a = 1; cyc(3); exit_a = 0;
        cyc(1);
        check_eq("t2_idle", int'(idle_a), 1);
        check_eq("a_sb_drained2", q_a.size(), 0);

        // Concurrent arrive/enter and enter/exit, then async reset mid-DRAIN.
        do_reset();
        for (int i = 0; i < 3; i++) q_a.push_back(0);
        e_arr_a = 1; cyc(2);
        check_eq("t5_e_wait2", int'(e_wait_a), 2);
        check_eq("t5_enter", int'(e_ent_a), 1);
        cyc(1); e_arr_a = 0;
        check_eq("t5_wait_hold", int'(e_wait_a), 2);
        check_eq("t5_occ1", int'(occ_a), 1);
        exit_a = 1; cyc(1); exit_a = 0;
        check_eq("t5_occ_hold", int'(occ_a), 1);
        check_eq("t5_e_wait1", int'(e_wait_a), 1);
        cyc(1);
        check_eq("t5_occ2", int'(occ_a), 2);
        w_arr_a = 1; cyc(1); w_arr_a = 0;
        cyc(1);
        check_eq("t6_in_drain", int'(e_go_a || w_go_a || idle_a), 0);
        check_eq("t6_drain_w_wait", int'(w_wait_a), 1);
        #3 reset = 1'b1;
        #1;
        check_eq("t6_rst_e_go", int'(e_go_a), 0);
        check_eq("t6_rst_w_go", int'(w_go_a), 0);
        check_eq("t6_rst_idle", int'(idle_a), 1);
        check_eq("t6_rst_occ", int'(occ_a), 0);
        check_eq("t6_rst_w_wait", int'(w_wait_a), 0);
        check_eq("t6_rst_e_wait", int'(e_wait_a), 0);
        check_eq("t6_rst_ovf", int'(ovf_a), 0);
        @(posedge clk); #1; reset = 1'b0;
        check_eq("a_sb_drained5", q_a.size(), 0);

        // Fairness, MAX_BURST=2: E,E then W then E,E,E; lane emptied every cycle.
        do_reset();
        q_b.push_back(0); q_b.push_back(0); q_b.push_back(1);
        q_b.push_back(0); q_b.push_back(0); q_b.push_back(0);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            e_arr_b = (i < 5);
            w_arr_b = (i == 0);
            exit_b  = (occ_b != 0);
            cyc(1);
            done = (i >= 5) && idle_b && (occ_b == 0) && (q_b.size() == 0);
        end
        e_arr_b = 0; w_arr_b = 0; exit_b = 0;
        check_eq("b_finished", int'(done), 1);
        check_eq("b_e_wait0", int'(e_wait_b), 0);
        check_eq("b_sb_drained", q_b.size(), 0);

        // Saturation, CNT_W=2: 4 east arrivals while DRAIN held by occ=1.
        do_reset();
        q_c.push_back(1);
        w_arr_c = 1; cyc(1); w_arr_c = 0;
        cyc(1);
        check_eq("c_w_go", int'(w_go_c), 1);
        for (int i = 0; i < 3; i++) q_c.push_back(0);
        e_arr_c = 1; cyc(1);
        check_eq("c_occ1", int'(occ_c), 1);
        cyc(1);
        check_eq("c_drain", int'(e_go_c || w_go_c || idle_c), 0);
        cyc(1);
        check_eq("c_e_wait3", int'(e_wait_c), 3);
        check_eq("c_no_ovf_yet", int'(ovf_c), 0);
        cyc(1); e_arr_c = 0;
        check_eq("c_e_wait_sat", int'(e_wait_c), 3);
        check_eq("c_ovf_arrive", int'(ovf_c), 1);
        exit_c = 1; cyc(1);
        check_eq("c_ovf_pulse_end", int'(ovf_c), 0);
        check_eq("c_occ0", int'(occ_c), 0);
        cyc(1); exit_c = 0;
        check_eq("c_ovf_exit", int'(ovf_c), 1);
        check_eq("c_occ_stays0", int'(occ_c), 0);
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            exit_c = (occ_c != 0);
            cyc(1);
            done = idle_c && (occ_c == 0) && (q_c.size() == 0);
        end
        exit_c = 0;
        check_eq("c_finished", int'(done), 1);
        check_eq("c_e_wait0", int'(e_wait_c), 0);
        check_eq("c_sb_drained", q_c.size(), 0);

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_dir_ctrl.md
# lane_dir_ctrl

Parametrised controller for a single shared lane used in two directions, east and west. It queues arrivals per direction and grants the lane to one direction at a time. Each burst is bounded, and the lane must fully drain plus a clearance time must pass before the direction reverses. It generalises the two-input east/west direction FSM to counted queues, occupancy tracking, fairness and configurable timing, and sits between the arrival sensors and the lane signal drivers.

## Interface
- CNT_W, 4: width of the waiting counters and the occupancy counter; counters saturate at 2^CNT_W-1.
- MAX_BURST, 8: maximum entries granted to one direction while the other side is waiting; legal range 1..2^CNT_W-1.
- CLEAR_CYCLES, 3: number of empty-lane cycles required before reversing direction; must be ≥1.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- e_arrive  in  1  one east vehicle arrives this cycle.
- w_arrive  in  1  one west vehicle arrives this cycle.
- exit  in  1  one vehicle left the lane this cycle.
- e_go  out  1  east signal green.
- w_go  out  1  west signal green.
- e_enter  out  1  one east vehicle admitted this cycle.
- w_enter  out  1  one west vehicle admitted this cycle.
- idle  out  1  lane unowned: state IDLE.
- occ  out  CNT_W  vehicles currently in the lane.
- e_wait  out  CNT_W  east queue depth.
- w_wait  out  CNT_W  west queue depth.
- ovf  out  1  one-cycle pulse when an arrival is dropped, or an exit arrives with occ==0.

## Operation
- States: IDLE, GO_E, GO_W, DRAIN.
- Registers: state, next_dir, last_dir, burst counter, clear timer.
- Reset values: state=IDLE, last_dir=WEST (so east is served first on a tie), all counters 0. Outputs after reset: e_go=w_go=e_enter=w_enter=0, idle=1, ovf=0.
- e_go = (state==GO_E). w_go = (state==GO_W). These are decoded from registered state only.
- e_enter = e_go && e_wait!=0. w_enter follows the same rule.
- Waiting counters:
  - +1 on arrive, -1 on enter; both in the same cycle leaves the count unchanged.
  - An arrival at saturation is dropped and pulses ovf.
- Occupancy:
  - +1 on any enter, -1 on exit; both in the same cycle leaves it unchanged.
  - An exit with occ==0 is ignored and pulses ovf.
- IDLE:
  - If both queues are non-zero, go to GO_(opposite of last_dir).
  - Otherwise go to GO_ for whichever queue is non-zero.
  - If neither is non-zero, stay in IDLE.
  - On entering any GO_ state, burst=0 and last_dir is set to that direction.
- GO_E (GO_W is the mirror image):
  - burst increments on each e_enter.
  - If w_wait!=0 and (e_wait==0 or burst==MAX_BURST): go to DRAIN with next_dir=WEST and clear timer=0.
  - Else if e_wait==0, w_wait==0 and occ==0: go to IDLE.
  - Otherwise stay in GO_E.
- DRAIN:
  - No grants are issued.
  - While occ!=0, the timer holds at 0.
  - While occ==0, the timer increments. When the timer reaches CLEAR_CYCLES-1 with occ==0, go to GO_(next_dir).
  - Arrivals during DRAIN are still counted.
- Invariant: e_go and w_go are never high together. A GO_ state is never entered while occ!=0 from the opposite direction.

## Timing
- Arrival to wait count: an arrival pulse in cycle t gives e_wait updated in cycle t+1.
- From IDLE: arrival in cycle t gives state GO_E and e_enter high in cycle t+2.
- Queued vehicles: one enter per cycle per granted direction.
- Reversal: after the last exit (occ reaches 0 in cycle t), the opposite go rises in cycle t+CLEAR_CYCLES.
- Reset is asynchronous. Asserting it mid-burst or mid-DRAIN immediately forces IDLE, drops all counts, and drives both go outputs low in the same cycle, with no clock edge needed.

## Structure
- Package lane_dir_pkg holds the state enum (IDLE, GO_E, GO_W, DRAIN) and the direction encoding (EAST, WEST).
- Sub-module sat_updown_cnt is a CNT_W-bit saturating up/down counter with inc, dec and ovf outputs. It is instantiated three times: e_wait, w_wait and occ.
- The top level contains the FSM, the burst counter, and the clear timer sized to CLEAR_CYCLES.

## Test plan
- Reset then single east arrival: e_arrive pulse at cycle 1 → e_enter at cycle 3 → occ=1, e_wait=0. With no further arrivals, an exit gives occ=0 and the next cycle shows IDLE with idle=1.
- Simultaneous 3 east and 3 west arrivals from reset: east is served first (3 enters). Three exits follow, then CLEAR_CYCLES=3 empty cycles, then w_go and 3 west enters. e_go and w_go are never high together.
- Fairness, MAX_BURST=2, 5 east queued and 1 west queued: exactly 2 east enters, then DRAIN, then 1 west enter, then DRAIN, then the remaining 3 east.
- Saturation, CNT_W=2: 4 east arrivals while DRAIN is held by occ!=0 gives e_wait=3 and one ovf pulse. An exit with occ==0 also gives an ovf pulse with occ staying 0.
- Simultaneous enter and exit in GO_E: occ holds its value. Simultaneous arrive and enter: e_wait holds its value.
- Reset asserted mid-DRAIN between clock edges: go outputs, counters and ovf all read 0 and idle reads 1 immediately, before the next clock edge.
